// File: rtl/eeprom_pkg.sv
// Shared types and helpers for the EEPROM self-test stimulus/check stage.
package eeprom_pkg;

    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam int EEPROM_PAGE_BYTES = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    // Byte k of a run: seed + run + k, wrapping mod 256.
    function automatic logic [7:0] pat(input logic [7:0] seed,
                                       input logic [7:0] run,
                                       input logic [7:0] k);
        return seed + run + k;
    endfunction

endpackage

// File: rtl/eeprom_selftest_pattern_chk.sv
// Test pattern generator plus read-back compare and error accumulation.
module selftest_pattern_chk
    import eeprom_pkg::*;
#(
    parameter logic [7:0]  P_SEED       = 8'hA5,
    parameter logic [15:0] P_START_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        run_inc,
    input  logic [5:0]  idx,
    output logic [7:0]  exp_byte,
    input  logic        cmp_en,
    input  logic [7:0]  cmp_data,
    input  logic [5:0]  miss_cnt,
    output logic [7:0]  err_cnt,
    output logic [15:0] first_err_addr
);

    logic [7:0] run_cnt;
    logic       err_seen;
    logic       mismatch;
    logic [9:0] err_sum;

    assign exp_byte = pat(P_SEED, run_cnt, {2'b00, idx});
    assign mismatch = cmp_en && (cmp_data != exp_byte);
    // A mismatch and a short-frame penalty can land on the same byte.
    assign err_sum  = {2'b00, err_cnt} + {9'd0, mismatch} + {4'd0, miss_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt        <= 8'd0;
            err_cnt        <= 8'd0;
            first_err_addr <= 16'hFFFF;
            err_seen       <= 1'b0;
        end else begin
            if (run_inc)
                run_cnt <= run_cnt + 8'd1;
            if (clear) begin
                err_cnt        <= 8'd0;
                first_err_addr <= 16'hFFFF;
                err_seen       <= 1'b0;
            end else begin
                err_cnt <= (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
                if (mismatch && !err_seen) begin
                    first_err_addr <= P_START_ADDR + {10'd0, idx};
                    err_seen       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eeprom_selftest.sv
// EEPROM page write / read-back self test: FSM, request handshake and watchdog.
module eeprom_selftest
    import eeprom_pkg::*;
#(
    parameter logic [2:0]  P_DEVICE_ADDR = 3'b000,
    parameter logic [15:0] P_START_ADDR  = 16'h0000,
    parameter int          P_LEN         = 8,
    parameter logic [7:0]  P_SEED        = 8'hA5,
    parameter int          P_TWR_CYCLES  = 250000,
    parameter int          P_TIMEOUT     = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_timeout,
    output logic [7:0]  o_err_cnt,
    output logic [15:0] o_first_err_addr,
    output logic [2:0]  o_user_device_addr,
    output logic [15:0] o_user_operate_addr,
    output logic [7:0]  o_user_operate_len,
    output logic [1:0]  o_user_operate_type,
    output logic        o_user_operate_valid,
    input  logic        i_user_operate_ready,
    output logic [7:0]  o_user_write_data,
    output logic        o_user_write_sop,
    output logic        o_user_write_eop,
    output logic        o_user_write_valid,
    input  logic [7:0]  i_user_read_data,
    input  logic        i_user_read_sop,
    input  logic        i_user_read_eop,
    input  logic        i_user_read_valid
);

    generate
        if (P_LEN < 1 || P_LEN > EEPROM_PAGE_BYTES ||
            (int'(P_START_ADDR) % EEPROM_PAGE_BYTES) + P_LEN > EEPROM_PAGE_BYTES) begin : g_bad_range
            $error("eeprom_selftest: test range must be 1..32 bytes inside one page");
        end
        if (P_TWR_CYCLES < 1 || P_TIMEOUT < 1) begin : g_bad_timing
            $error("eeprom_selftest: P_TWR_CYCLES and P_TIMEOUT must be >= 1");
        end
    endgenerate

    localparam logic [5:0] LAST = 6'(P_LEN - 1);

    state_t      state, state_nx;
    logic [5:0]  idx;
    logic [31:0] wd_cnt;
    logic        hs, wd_hit, wd_expire;
    logic        start_ok, rd_byte, rd_last;
    logic [5:0]  miss_cnt;
    logic [7:0]  exp_byte;
    logic        timeout_q, result_vld;
    logic        unused_sop;

    // Frame start is implied by entering RD_DATA; the incoming sop is not needed.
    assign unused_sop = i_user_read_sop;

    assign hs       = o_user_operate_valid & i_user_operate_ready;
    assign wd_hit   = (wd_cnt == 32'(P_TIMEOUT - 1));
    assign start_ok = (state == ST_IDLE) & i_start;
    assign rd_byte  = (state == ST_RD_DATA) & i_user_read_valid;
    assign rd_last  = rd_byte & (i_user_read_eop | (idx == LAST));
    assign miss_cnt = (rd_byte & i_user_read_eop) ? (LAST - idx) : 6'd0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        wd_expire = 1'b0;
        case (state)
            ST_IDLE:    if (i_start) state_nx = ST_WR_REQ;
            ST_WR_REQ: begin
                if (hs)          state_nx = ST_WR_DATA;
                else if (wd_hit) begin state_nx = ST_DONE; wd_expire = 1'b1; end
            end
            ST_WR_DATA: if (idx == LAST) state_nx = ST_WR_WAIT;
            ST_WR_WAIT: if (wd_cnt == 32'(P_TWR_CYCLES - 1)) state_nx = ST_RD_REQ;
            ST_RD_REQ: begin
                if (hs)          state_nx = ST_RD_DATA;
                else if (wd_hit) begin state_nx = ST_DONE; wd_expire = 1'b1; end
            end
            ST_RD_DATA: begin
                if (rd_last)     state_nx = ST_DONE;
                else if (wd_hit) begin state_nx = ST_DONE; wd_expire = 1'b1; end
            end
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Watchdog and byte index both restart on every state change.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wd_cnt     <= 32'd0;
            idx        <= 6'd0;
            timeout_q  <= 1'b0;
            result_vld <= 1'b0;
        end else begin
            if (state_nx != state) begin
                wd_cnt <= 32'd0;
                idx    <= 6'd0;
            end else begin
                if (wd_cnt != '1)
                    wd_cnt <= wd_cnt + 32'd1;
                if (o_user_write_valid || rd_byte)
                    idx <= idx + 6'd1;
            end
            if (wd_expire)
                timeout_q <= 1'b1;
            else if (start_ok)
                timeout_q <= 1'b0;
            if (state == ST_DONE)
                result_vld <= 1'b1;
            else if (start_ok)
                result_vld <= 1'b0;
        end
    end

    selftest_pattern_chk #(
        .P_SEED       (P_SEED),
        .P_START_ADDR (P_START_ADDR)
    ) u_chk (
        .clk            (i_clk),
        .rst_n          (i_rst),
        .clear          (start_ok),
        .run_inc        (state == ST_DONE),
        .idx            (idx),
        .exp_byte       (exp_byte),
        .cmp_en         (rd_byte),
        .cmp_data       (i_user_read_data),
        .miss_cnt       (miss_cnt),
        .err_cnt        (o_err_cnt),
        .first_err_addr (o_first_err_addr)
    );

    // Strobes decode straight from state so an async reset drops them at once.
    assign o_busy               = (state != ST_IDLE) && (state != ST_DONE);
    assign o_done               = (state == ST_DONE);
    assign o_timeout            = timeout_q;
    assign o_pass               = (o_done | result_vld) & (o_err_cnt == 8'd0) & ~timeout_q;
    assign o_user_device_addr   = P_DEVICE_ADDR;
    assign o_user_operate_addr  = P_START_ADDR;
    assign o_user_operate_len   = 8'(P_LEN);
    assign o_user_operate_valid = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign o_user_operate_type  = (state == ST_WR_REQ) ? OP_WRITE :
                                  (state == ST_RD_REQ) ? OP_READ  : 2'd0;
    assign o_user_write_valid   = (state == ST_WR_DATA);
    assign o_user_write_sop     = o_user_write_valid && (idx == 6'd0);
    assign o_user_write_eop     = o_user_write_valid && (idx == LAST);
    assign o_user_write_data    = o_user_write_valid ? exp_byte : 8'd0;

endmodule

// File: tb/tb_eeprom_selftest.sv
// Scoreboard bench: echo-memory responder plus queued expected write bytes and run results.
module tb_eeprom_selftest;
    import eeprom_pkg::*;

    localparam int          LEN   = 8;
    localparam int          TWR   = 20;
    localparam int          TMO   = 300;
    localparam int          HOLD  = 40;
    localparam int          LIMIT = 2 * TMO + 400;
    localparam logic [7:0]  SEED  = 8'hA5;
    localparam logic [15:0] SADDR = 16'h0000;

    logic        i_clk, i_rst, i_start;
    logic        o_busy, o_done, o_pass, o_timeout;
    logic [7:0]  o_err_cnt;
    logic [15:0] o_first_err_addr;
    logic [2:0]  o_user_device_addr;
    logic [15:0] o_user_operate_addr;
    logic [7:0]  o_user_operate_len;
    logic [1:0]  o_user_operate_type;
    logic        o_user_operate_valid, i_user_operate_ready;
    logic [7:0]  o_user_write_data;
    logic        o_user_write_sop, o_user_write_eop, o_user_write_valid;
    logic [7:0]  i_user_read_data;
    logic        i_user_read_sop, i_user_read_eop, i_user_read_valid;

    eeprom_selftest #(
        .P_DEVICE_ADDR (3'b101),
        .P_START_ADDR  (SADDR),
        .P_LEN         (LEN),
        .P_SEED        (SEED),
        .P_TWR_CYCLES  (TWR),
        .P_TIMEOUT     (TMO)
    ) dut (
        .i_clk                (i_clk),
        .i_rst                (i_rst),
        .i_start              (i_start),
        .o_busy               (o_busy),
        .o_done               (o_done),
        .o_pass               (o_pass),
        .o_timeout            (o_timeout),
        .o_err_cnt            (o_err_cnt),
        .o_first_err_addr     (o_first_err_addr),
        .o_user_device_addr   (o_user_device_addr),
        .o_user_operate_addr  (o_user_operate_addr),
        .o_user_operate_len   (o_user_operate_len),
        .o_user_operate_type  (o_user_operate_type),
        .o_user_operate_valid (o_user_operate_valid),
        .i_user_operate_ready (i_user_operate_ready),
        .o_user_write_data    (o_user_write_data),
        .o_user_write_sop     (o_user_write_sop),
        .o_user_write_eop     (o_user_write_eop),
        .o_user_write_valid   (o_user_write_valid),
        .i_user_read_data     (i_user_read_data),
        .i_user_read_sop      (i_user_read_sop),
        .i_user_read_eop      (i_user_read_eop),
        .i_user_read_valid    (i_user_read_valid)
    );

    typedef struct packed {
        logic        pass;
        logic        tmo;
        logic [7:0]  err;
        logic [15:0] first;
    } res_t;

    logic [7:0] wq[$];
    res_t       rq[$];

    int n_chk = 0;
    int n_pass = 0;

    // responder controls (written by main) and observations (written by responder)
    int rdy_mode = 0;       // 0: always ready, 1: hold low HOLD cycles, 2: never ready
    int corrupt_idx = -1;
    int n_send = LEN;
    int xfer_cnt = 0, done_cnt = 0, wr_req_cyc = 0, type_glitch = 0;
    logic [7:0] model_run = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Echo-memory responder and output monitor; one process, sampled on the falling edge.
    initial begin
        logic [7:0] mem [0:LEN-1];
        int   wr_beat, rd_k, req_wait;
        logic rd_active, prev_vld, rdy;
        logic [1:0] prev_type;
        logic [7:0] eb;
        res_t r;
        wr_beat = 0; rd_k = 0; req_wait = 0; rd_active = 0; prev_vld = 0; prev_type = 2'd0;
        for (int i = 0; i < LEN; i++) mem[i] = 8'd0;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                wr_beat = 0; rd_active = 0; req_wait = 0; prev_vld = 0;
                i_user_operate_ready = (rdy_mode == 0);
                i_user_read_valid = 1'b0; i_user_read_sop = 1'b0; i_user_read_eop = 1'b0;
            end else begin
                if (o_user_write_valid) begin
                    if (wq.size() == 0) chk("wr_extra", 1, 0);
                    else begin
                        eb = wq.pop_front();
                        chk("wr_data", o_user_write_data, eb);
                    end
                    chk("wr_sop", o_user_write_sop, wr_beat == 0);
                    chk("wr_eop", o_user_write_eop, wr_beat == LEN - 1);
                    mem[wr_beat] = o_user_write_data;
                    wr_beat = (wr_beat == LEN - 1) ? 0 : wr_beat + 1;
                end
                if (o_done) begin
                    done_cnt++;
                    if (rq.size() == 0) chk("done_extra", 1, 0);
                    else begin
                        r = rq.pop_front();
                        chk("done_pass", o_pass, r.pass);
                        chk("done_tmo", o_timeout, r.tmo);
                        chk("done_err", o_err_cnt, r.err);
                        chk("done_first", o_first_err_addr, r.first);
                        chk("done_busy", o_busy, 0);
                    end
                end
                if (rd_active) begin
                    i_user_read_valid = 1'b1;
                    i_user_read_data  = (rd_k == corrupt_idx) ? 8'h00 : mem[rd_k];
                    i_user_read_sop   = (rd_k == 0);
                    i_user_read_eop   = (rd_k == n_send - 1);
                    rd_k++;
                    if (rd_k == n_send) rd_active = 0;
                end else begin
                    i_user_read_valid = 1'b0; i_user_read_sop = 1'b0; i_user_read_eop = 1'b0;
                end
                if (o_user_operate_valid) begin
                    if (prev_vld && o_user_operate_type != prev_type) type_glitch++;
                    if (o_user_operate_type == OP_WRITE) wr_req_cyc++;
                    case (rdy_mode)
                        0:       rdy = 1'b1;
                        1:       rdy = (req_wait >= HOLD);
                        default: rdy = 1'b0;
                    endcase
                    i_user_operate_ready = rdy;
                    if (rdy) begin
                        xfer_cnt++; req_wait = 0; prev_vld = 0;
                        if (o_user_operate_type == OP_READ) begin rd_active = 1; rd_k = 0; end
                    end else begin
                        req_wait++; prev_vld = 1; prev_type = o_user_operate_type;
                    end
                end else begin
                    i_user_operate_ready = (rdy_mode == 0);
                    req_wait = 0; prev_vld = 0;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge i_clk); i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int cyc = 0;
        while (done_cnt == d0 && cyc < LIMIT) begin
            @(posedge i_clk); cyc++;
        end
        #1 chk("done_seen", done_cnt != d0, 1);
    endtask

    task automatic push_writes();
        for (int k = 0; k < LEN; k++) wq.push_back(SEED + model_run + 8'(k));
    endtask

    task automatic run_test(input logic ep, input logic et, input logic [7:0] ee,
                            input logic [15:0] ef, input bit writes);
        int d0;
        if (writes) push_writes();
        rq.push_back('{pass: ep, tmo: et, err: ee, first: ef});
        d0 = done_cnt;
        pulse_start();
        #1 chk("busy_after_start", o_busy, 1);
        wait_done(d0);
        model_run++;
        repeat (2) @(posedge i_clk);
        #1 chk("pass_hold", o_pass, ep);
    endtask

    initial begin
        int x0, w0, g0, d0, cyc;
        i_rst = 1'b0; i_start = 1'b0;
        i_user_operate_ready = 1'b1; i_user_read_data = 8'd0;
        i_user_read_sop = 1'b0; i_user_read_eop = 1'b0; i_user_read_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_pass", o_pass, 0);
        chk("rst_tmo", o_timeout, 0);
        chk("rst_err", o_err_cnt, 0);
        chk("rst_first", o_first_err_addr, 16'hFFFF);
        chk("rst_opvalid", o_user_operate_valid, 0);
        chk("rst_optype", o_user_operate_type, 0);
        chk("rst_wrvalid", o_user_write_valid, 0);
        chk("dev_addr", o_user_device_addr, 3'b101);
        chk("op_addr", o_user_operate_addr, SADDR);
        chk("op_len", o_user_operate_len, LEN);
        @(negedge i_clk); i_rst = 1'b1;
        repeat (2) @(posedge i_clk);

        // run 0 (A5..AC) and run 1 (A6..AD), ideal memory
        run_test(1'b1, 1'b0, 8'd0, 16'hFFFF, 1'b1);
        run_test(1'b1, 1'b0, 8'd0, 16'hFFFF, 1'b1);

        // byte 3 read back as 00
        corrupt_idx = 3;
        run_test(1'b0, 1'b0, 8'd1, SADDR + 16'd3, 1'b1);
        corrupt_idx = -1;

        // ready held low for HOLD cycles on each request
        x0 = xfer_cnt; w0 = wr_req_cyc; g0 = type_glitch;
        rdy_mode = 1;
        run_test(1'b1, 1'b0, 8'd0, 16'hFFFF, 1'b1);
        rdy_mode = 0;
        chk("hold_wr_valid_cycles", wr_req_cyc - w0, HOLD + 1);
        chk("hold_xfers", xfer_cnt - x0, 2);
        chk("hold_type_stable", type_glitch - g0, 0);

        // ready never asserts: watchdog aborts in WR_REQ
        x0 = xfer_cnt;
        rdy_mode = 2;
        run_test(1'b0, 1'b1, 8'd0, 16'hFFFF, 1'b0);
        rdy_mode = 0;
        chk("tmo_no_xfer", xfer_cnt - x0, 0);

        // early eop after 5 of 8 bytes
        n_send = 5;
        run_test(1'b0, 1'b0, 8'd3, 16'hFFFF, 1'b1);
        n_send = LEN;

        // reset in the middle of the write burst
        push_writes();
        d0 = done_cnt;
        pulse_start();
        cyc = 0;
        while (!o_user_write_valid && cyc < 50) begin @(posedge i_clk); #1; cyc++; end
        chk("reach_wr_data", o_user_write_valid, 1);
        @(posedge i_clk); #2 i_rst = 1'b0;
        #1;
        chk("arst_wrvalid", o_user_write_valid, 0);
        chk("arst_opvalid", o_user_operate_valid, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_first", o_first_err_addr, 16'hFFFF);
        wq.delete(); rq.delete();
        model_run = 8'd0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk); i_rst = 1'b1;
        repeat (40) @(posedge i_clk);
        #1 chk("arst_no_done", done_cnt - d0, 0);

        // clean run after reset, with a second start while busy
        x0 = xfer_cnt;
        push_writes();
        rq.push_back('{pass: 1'b1, tmo: 1'b0, err: 8'd0, first: 16'hFFFF});
        d0 = done_cnt;
        pulse_start();
        repeat (5) @(posedge i_clk);
        pulse_start();
        wait_done(d0);
        model_run++;
        repeat (20) @(posedge i_clk);
        #1;
        chk("busy_start_xfers", xfer_cnt - x0, 2);
        chk("busy_start_dones", done_cnt - d0, 1);

        // walk run counter through 255 and back to 0
        for (int i = 0; i < 256; i++) run_test(1'b1, 1'b0, 8'd0, 16'hFFFF, 1'b1);
        chk("run_wrapped", model_run, 8'd1);
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eeprom_selftest.md
Name: eeprom_selftest

Overview:
- Upstream stimulus/check stage for the IIC EEPROM top-level block; drives its user operation, write and read interfaces.
- On a start pulse it writes a deterministic byte pattern to one EEPROM page and waits the write-cycle time.
- It then reads the same range back and compares every byte.
- Reports pass/fail, error count and first failing address; used for board bring-up and as the on-chip regression source.

Parameters:
- P_DEVICE_ADDR, 3'b000, EEPROM device select bits driven on o_user_device_addr.
- P_START_ADDR, 16'h0000, first byte address of the test range.
- P_LEN, 8, bytes per run. Legal range 1..32; the range must not cross a 32-byte page. Checked by an elaboration-time assertion.
- P_SEED, 8'hA5, pattern seed.
- P_TWR_CYCLES, 250000, idle cycles between write end and read start (5 ms at 50 MHz).
- P_TIMEOUT, 1000000, watchdog limit in cycles for any single wait state.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: asynchronous, active-low reset.
- i_start, in, 1: single-cycle start pulse; ignored while o_busy=1.
- o_busy, out, 1: high from accepted start until o_done.
- o_done, out, 1: one-cycle pulse at end of run.
- o_pass, out, 1: valid from o_done until the next start; 1 = all bytes matched, no timeout.
- o_timeout, out, 1: last run aborted by watchdog.
- o_err_cnt, out, 8: mismatched plus missing bytes, saturating at 255.
- o_first_err_addr, out, 16: address of first mismatch; 16'hFFFF if none.
- o_user_device_addr, out, 3: constant P_DEVICE_ADDR.
- o_user_operate_addr, out, 16: constant P_START_ADDR.
- o_user_operate_len, out, 8: P_LEN.
- o_user_operate_type, out, 2: operation code, see package.
- o_user_operate_valid, out, 1: operation request.
- i_user_operate_ready, in, 1: downstream accepts the request.
- o_user_write_data, out, 8: write byte.
- o_user_write_sop / o_user_write_eop / o_user_write_valid, out, 1 each: write framing.
- i_user_read_data, in, 8: read byte.
- i_user_read_sop / i_user_read_eop / i_user_read_valid, in, 1 each: read framing.

Behaviour:
- Reset: all outputs 0, except o_first_err_addr = 16'hFFFF and the constant address/device outputs. Run counter cleared. Reset mid-run aborts at once: valid strobes drop asynchronously and no o_done is generated.
- Pattern: byte k = P_SEED + run_cnt + k, mod 256. run_cnt (8 bit) increments at each o_done and wraps, so successive runs write different data.
- Handshake: a request transfers on the cycle where o_user_operate_valid & i_user_operate_ready. Valid is held, with type stable, until that cycle and deasserts the cycle after.
- FSM states: IDLE -> WR_REQ -> WR_DATA -> WR_WAIT -> RD_REQ -> RD_DATA -> DONE -> IDLE.
- IDLE: on i_start, clear o_err_cnt, o_first_err_addr, o_pass and o_timeout; set o_busy; go to WR_REQ.
- WR_REQ: type = OP_WRITE, valid high; on handshake go to WR_DATA.
- WR_DATA: starts the cycle after the handshake. P_LEN contiguous cycles with o_user_write_valid=1. sop on k=0, eop on k=P_LEN-1; sop and eop are both set when P_LEN=1. Then go to WR_WAIT.
- WR_WAIT: count P_TWR_CYCLES, then go to RD_REQ.
- RD_REQ: type = OP_READ, valid high; on handshake go to RD_DATA.
- RD_DATA: on each i_user_read_valid, compare the byte with pattern k and increment k.
  - On mismatch: o_err_cnt+1; record P_START_ADDR+k if this is the first error.
  - Exit on i_user_read_eop or k reaching P_LEN.
  - If eop arrives with k < P_LEN, add the missing count (P_LEN-k-1) to o_err_cnt, saturating.
  - Bytes arriving after exit are ignored; read strobes outside RD_DATA are ignored.
- Watchdog: counter cleared on each state change. Reaching P_TIMEOUT in WR_REQ, RD_REQ or RD_DATA sets o_timeout=1 and goes to DONE; any valid strobe drops the next cycle.
- DONE: o_done=1 for one cycle; o_pass = (o_err_cnt==0) & ~o_timeout; o_busy drops the same cycle.
- i_start asserted during DONE is ignored.

Decomposition:
- Package eeprom_pkg holds:
  - operation codes OP_WRITE=2'd1 and OP_READ=2'd2;
  - EEPROM_PAGE_BYTES=32;
  - the state enum;
  - the pattern function pat(seed, run, k).
- One sub-module, selftest_pattern_chk: pattern generation plus compare/error accumulation.
- FSM, watchdog and handshake logic stay in the top.

Test Plan:
- Default params, model with ready=1 and ideal echo memory; pulse start -> 8 write bytes A5..AC with sop on byte 0 and eop on byte 7; read request after 250000 cycles; o_done with o_pass=1, o_err_cnt=0, o_first_err_addr=FFFF.
- Second run -> written pattern A6..AD; pass; run_cnt wraps from 255 to 0 without error.
- Model corrupts byte 3 (returns 00) -> o_err_cnt=1, o_first_err_addr=0003, o_pass=0.
- Ready held low for 40 cycles in WR_REQ -> valid stays high and type stable throughout; one transfer only.
- Ready never asserts -> after 1000000 cycles o_timeout=1, o_done pulses, o_pass=0; early eop after 5 of 8 bytes -> o_err_cnt=3.
- Assert i_rst low mid WR_DATA -> all valids 0 immediately, o_busy=0, no o_done; a later start runs cleanly; start during busy is ignored (single request observed).
